ct_f_spsram_512x52_ctrl: RTL and testbench
==========================================

# ct_f_spsram_512x52_ctrl

Access controller directly upstream of the 512x52 single-port SRAM macro. Accepts read/write requests over a valid/ready handshake and zero-initialises the array after reset. Drives the macro's active-low CEN/GWEN/WEN, A and D pins, and returns read data in order through a small response FIFO with backpressure. One SRAM access per cycle, no reordering.

## Interface
Parameters:
- ADDR_WIDTH, 9, SRAM address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 52, word width; always two equal halves of DATA_WIDTH/2
- INIT_EN, 1, 1 = sweep-write INIT_VALUE to every address after reset
- INIT_VALUE, 0, DATA_WIDTH-bit fill value
- RSP_DEPTH, 3, response FIFO entries (min 2; 3 gives full read throughput)

Ports:
- CLK  in  1  clock; also clocks the SRAM macro
- RST  in  1  reset, synchronous, active-high
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_wmask  in  2  per-half write enable, active-high: bit0 = [25:0], bit1 = [51:26]
- rsp_vld  out  1  read data valid
- rsp_rdy  in  1  read data consumed
- rsp_data  out  DATA_WIDTH  read data
- init_done  out  1  initialisation complete; requests accepted only when 1
- A  out  ADDR_WIDTH  SRAM address
- CEN  out  1  SRAM chip enable, active-low
- GWEN  out  1  SRAM global write enable, active-low
- WEN  out  DATA_WIDTH  SRAM bit write enables, active-low
- D  out  DATA_WIDTH  SRAM write data
- Q  in  DATA_WIDTH  SRAM read data; valid the cycle after a read access

## Operation
- States: INIT and RUN. RST forces INIT with sweep counter = 0 if INIT_EN=1, otherwise RUN.
- INIT: each cycle drive CEN=0, GWEN=0, WEN=all 0, A=counter, D=INIT_VALUE, then increment. After address 2^ADDR_WIDTH-1 is written, go to RUN. req_rdy=0 throughout.
- init_done = (state==RUN), registered.
- Credits: req_rdy = init_done && (fifo_occ + rd_inflight < RSP_DEPTH). Independent of req_wr and of rsp_rdy; no combinational rsp_rdy->req_rdy path.
- Accepted write (req_vld&&req_rdy&&req_wr), same cycle: CEN=0, GWEN=0, A=req_addr, D=req_wdata, WEN[25:0]={26{~req_wmask[0]}}, WEN[51:26]={26{~req_wmask[1]}}. Mask 00 still performs the access and writes no bits. No response is generated.
- Accepted read, same cycle: CEN=0, GWEN=1, WEN=all 1, A=req_addr, D=0; rd_inflight<=1. Next cycle: Q is pushed into the FIFO and rd_inflight clears unless a new read is accepted.
- No access (RUN, or while RST=1): CEN=1, GWEN=1, WEN=all 1, A=0, D=0. SRAM pins are combinational from state and request.
- FIFO: in order, rsp_data = head, rsp_vld = !empty. Pop on rsp_vld&&rsp_rdy. Push and pop in the same cycle are allowed, with occupancy unchanged. Credits guarantee no push when full.
- A read issued any cycle after a write to the same address returns the written data.

## Timing
- Reset values (cycle after RST high): rsp_vld=0, init_done=0 (1 if INIT_EN=0), req_rdy=0, FIFO empty, rd_inflight=0. SRAM pins are idle while RST=1.
- RST mid-operation: sweep, FIFO contents and in-flight read are discarded. Any in-flight Q is not pushed.
- INIT lasts exactly 2^ADDR_WIDTH cycles after RST falls. init_done=1 in the following cycle (cycle 513 for defaults, counting the first sweep cycle as 1).
- INIT_EN=0: init_done=1 and req_rdy can be 1 in the first cycle after RST falls.
- Read latency: accept in cycle N, Q at N+1, rsp_vld at N+2 (FIFO was empty).
- With rsp_rdy held 1 and RSP_DEPTH=3, one read is accepted per cycle indefinitely.
- With rsp_rdy=0, at most RSP_DEPTH reads are accepted before req_rdy=0. req_rdy returns the cycle after the first pop.

## Test plan
- Reset with INIT_EN=1 -> 512 cycles of CEN=0/GWEN=0 with A=0..511 in order, init_done=1 at cycle 513; read of 0x1FF returns 52'h0.
- Write addr 0x0A5, data all-ones, mask 2'b01, then read 0x0A5 -> rsp_data[25:0]=all ones, [51:26]=0; WEN[25:0]=0 and WEN[51:26]=all 1 during the write.
- Reads of addresses 1..8 on consecutive cycles with rsp_rdy=1, after writes data=addr*3 -> req_rdy stays 1, responses 3,6,...,24 in order, first at 2 cycles latency.
- rsp_rdy=0 with reads offered continuously -> exactly 3 accepted, then req_rdy=0 for 10 cycles. rsp_rdy=1 -> 3 responses in order, no loss or duplication, req_rdy returns after the first pop.
- RST pulse while sweep A=100 and, separately, with 2 responses queued -> rsp_vld=0 the next cycle, sweep restarts at A=0, no stale response appears.
- INIT_EN=0 -> init_done=1 one cycle after RST falls, CEN never 0 without a request.

Source files
------------

// File: rtl/ct_f_spsram_512x52_ctrl.sv
// Access controller for the 512x52 single-port SRAM macro: zero-fill sweep after reset,
// valid/ready request port, and an in-order read response FIFO sized by credits.
module ct_f_spsram_512x52_ctrl #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 52,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    RSP_DEPTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW   = $clog2(RSP_DEPTH + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_initDone;
  logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_occ;
  logic                  r_rdInflight;

  logic [CW:0] w_used;
  logic        w_accept;
  logic        w_wrAcc;
  logic        w_rdAcc;
  logic        w_initAcc;
  logic        w_push;
  logic        w_pop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A request is only granted when its eventual response is guaranteed a FIFO slot.
  assign w_used    = {1'b0, r_occ} + {{CW{1'b0}}, r_rdInflight};
  assign req_rdy   = r_initDone && !RST && (w_used < (CW+1)'(RSP_DEPTH));
  assign w_accept  = req_vld && req_rdy;
  assign w_wrAcc   = w_accept && req_wr;
  assign w_rdAcc   = w_accept && !req_wr;
  assign w_initAcc = (r_state == ST_INIT) && !RST;
  assign w_push    = r_rdInflight;
  assign w_pop     = (r_occ != '0) && rsp_rdy;

  assign init_done = r_initDone;
  assign rsp_vld   = (r_occ != '0);
  assign rsp_data  = r_fifo[r_rdPtr];

  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    A    = '0;
    D    = '0;
    if (w_initAcc) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
      A    = r_cnt;
      D    = INIT_VALUE;
    end else if (w_wrAcc) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = {{(DATA_WIDTH-HALF){~req_wmask[1]}}, {HALF{~req_wmask[0]}}};
      A    = req_addr;
      D    = req_wdata;
    end else if (w_rdAcc) begin
      CEN  = 1'b0;
      A    = req_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      r_cnt      <= '0;
      r_initDone <= (INIT_EN == 0);
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + ADDR_WIDTH'(1);
      if (r_cnt == '1) begin
        r_state    <= ST_RUN;
        r_initDone <= 1'b1;
      end
    end
  end

  // Q belongs to the read issued last cycle; reset drops it along with the queue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_occ        <= '0;
      r_rdInflight <= 1'b0;
    end else begin
      r_rdInflight <= w_rdAcc;
      if (w_push) begin
        r_fifo[r_wrPtr] <= Q;
        r_wrPtr         <= nextPtr(r_wrPtr);
      end
      if (w_pop) r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_ct_f_spsram_512x52_ctrl.sv
// Directed bench for ct_f_spsram_512x52_ctrl with a behavioural SRAM macro model
// and a second instance built with INIT_EN=0.
module tb_ct_f_spsram_512x52_ctrl;

  localparam int AW = 9;
  localparam int DW = 52;
  localparam logic [DW-1:0] ONES = '1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          reqVld, reqRdy, reqWr, rspVld, rspRdy, initDone, cen, gwen;
  logic [AW-1:0] reqAddr, sramA;
  logic [DW-1:0] reqWdata, rspData, wen, sramD, q;
  logic [1:0]    reqWmask;

  logic          reqRdy0, rspVld0, initDone0, cen0, gwen0;
  logic [AW-1:0] sramA0;
  logic [DW-1:0] rspData0, wen0, sramD0;

  ct_f_spsram_512x52_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_vld(reqVld), .req_rdy(reqRdy), .req_wr(reqWr), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_wmask(reqWmask),
    .rsp_vld(rspVld), .rsp_rdy(rspRdy), .rsp_data(rspData), .init_done(initDone),
    .A(sramA), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(sramD), .Q(q)
  );

  ct_f_spsram_512x52_ctrl #(.INIT_EN(0)) dut0 (
    .CLK(CLK), .RST(RST),
    .req_vld(1'b0), .req_rdy(reqRdy0), .req_wr(1'b0), .req_addr('0),
    .req_wdata('0), .req_wmask(2'b00),
    .rsp_vld(rspVld0), .rsp_rdy(1'b1), .rsp_data(rspData0), .init_done(initDone0),
    .A(sramA0), .CEN(cen0), .GWEN(gwen0), .WEN(wen0), .D(sramD0), .Q('0)
  );

  // SRAM macro: active-low controls, bit-masked write, registered read data.
  logic [DW-1:0] mem [2**AW];
  always @(posedge CLK) begin
    if (!cen) begin
      if (!gwen) mem[sramA] <= (mem[sramA] & wen) | (sramD & ~wen);
      else       q <= mem[sramA];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [DW-1:0] rspQ[$];
  int            rspCycQ[$];
  int            cen0Low = 0;
  always @(negedge CLK) begin
    if (rspVld && rspRdy) begin
      rspQ.push_back(rspData);
      rspCycQ.push_back(cyc);
    end
    if (!cen0) cen0Low++;
  end

  int nVec = 0;
  int nMis = 0;

  logic [AW-1:0] snapA;
  logic          snapCen, snapGwen;
  logic [DW-1:0] snapWen, snapD;
  int            acceptCyc;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offers one request until accepted; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [1:0] wmask,
                               output int waited);
    bit got;
    got      = 0;
    waited   = 0;
    reqVld   = 1'b1;
    reqWr    = wr;
    reqAddr  = addr;
    reqWdata = wdata;
    reqWmask = wmask;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge CLK);
      if (reqRdy) begin
        got       = 1;
        snapA     = sramA;
        snapCen   = cen;
        snapGwen  = gwen;
        snapWen   = wen;
        snapD     = sramD;
        acceptCyc = cyc;
      end else begin
        waited++;
      end
      @(posedge CLK);
      #1;
    end
    reqVld = 1'b0;
    if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitRsp(input int n);
    for (int i = 0; i < 64 && rspQ.size() < n; i++) @(posedge CLK);
    #1;
    if (rspQ.size() < n) checkOutput("rsp_timeout", 64'(rspQ.size()), 64'(n));
  endtask

  task automatic doReset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("rst_rsp_vld", 64'(rspVld), 64'd0);
    checkOutput("rst_init_done", 64'(initDone), 64'd0);
    checkOutput("rst_req_rdy", 64'(reqRdy), 64'd0);
    checkOutput("rst_cen_idle", 64'(cen), 64'd1);
    checkOutput("rst_init_done_noinit", 64'(initDone0), 64'd1);
    RST = 1'b0;
    #1;
    checkOutput("noinit_req_rdy", 64'(reqRdy0), 64'd1);
    checkOutput("init_done_low", 64'(initDone), 64'd0);
  endtask

  // Enters just after RST falls: expects A=0..511 in order, then init_done in cycle 513.
  task automatic sweepCheck();
    int bad, firstBad;
    bad      = 0;
    firstBad = -1;
    for (int i = 0; i < 2**AW; i++) begin
      @(negedge CLK);
      if (cen !== 1'b0 || gwen !== 1'b0 || wen !== '0 || sramA !== AW'(i) ||
          sramD !== '0 || reqRdy !== 1'b0 || initDone !== 1'b0) begin
        if (bad == 0) firstBad = i;
        bad++;
      end
      @(posedge CLK);
      #1;
    end
    checkOutput("sweep_first_bad", 64'(firstBad), 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge CLK);
    checkOutput("init_done_513", 64'(initDone), 64'd1);
    checkOutput("req_rdy_513", 64'(reqRdy), 64'd1);
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    wmask;
    logic [DW-1:0] expWen;
    logic [DW-1:0] expRd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int waited, totalWaited, firstAcc, accepted, rdyLow;
    vecs[0]  = '{1'b0, 9'h1FF, '0, 2'b00, ONES, '0};
    vecs[1]  = '{1'b1, 9'h0A5, ONES, 2'b01, {26'h3FFFFFF, 26'h0}, '0};
    vecs[2]  = '{1'b0, 9'h0A5, '0, 2'b00, ONES, {26'h0, 26'h3FFFFFF}};
    vecs[3]  = '{1'b1, 9'h0A5, ONES, 2'b10, {26'h0, 26'h3FFFFFF}, '0};
    vecs[4]  = '{1'b0, 9'h0A5, '0, 2'b00, ONES, ONES};
    vecs[5]  = '{1'b1, 9'h010, ONES, 2'b00, ONES, '0};
    vecs[6]  = '{1'b0, 9'h010, '0, 2'b00, ONES, '0};
    vecs[7]  = '{1'b1, 9'h123, {26'h2AAAAAA, 26'h1555555}, 2'b11, '0, '0};
    vecs[8]  = '{1'b0, 9'h123, '0, 2'b00, ONES, {26'h2AAAAAA, 26'h1555555}};
    vecs[9]  = '{1'b1, 9'h123, '0, 2'b01, {26'h3FFFFFF, 26'h0}, '0};
    vecs[10] = '{1'b0, 9'h123, '0, 2'b00, ONES, {26'h2AAAAAA, 26'h0}};

    reqVld = 1'b0; reqWr = 1'b0; reqAddr = '0; reqWdata = '0; reqWmask = 2'b00;
    rspRdy = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    doReset();
    sweepCheck();

    foreach (vecs[v]) begin
      rspQ.delete();
      rspCycQ.delete();
      applyStimulus(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, waited);
      if (vecs[v].wr) begin
        checkOutput("wr_pins", {snapCen, snapGwen, snapA}, {1'b0, 1'b0, vecs[v].addr});
        checkOutput("wr_wen", snapWen, vecs[v].expWen);
        checkOutput("wr_d", snapD, vecs[v].wdata);
      end else begin
        checkOutput("rd_pins", {snapCen, snapGwen, snapA}, {1'b0, 1'b1, vecs[v].addr});
        checkOutput("rd_wen_d", {snapWen, 12'h0}, {ONES, 12'h0});
        waitRsp(1);
        if (rspQ.size() >= 1) checkOutput("rd_data", rspQ[0], vecs[v].expRd);
      end
    end

    // Back-to-back reads with rsp_rdy held high must never stall.
    for (int a = 1; a <= 8; a++) applyStimulus(1'b1, AW'(a), DW'(a * 3), 2'b11, waited);
    repeat (2) @(posedge CLK);
    #1;
    rspQ.delete();
    rspCycQ.delete();
    totalWaited = 0;
    firstAcc    = 0;
    for (int a = 1; a <= 8; a++) begin
      applyStimulus(1'b0, AW'(a), '0, 2'b00, waited);
      totalWaited += waited;
      if (a == 1) firstAcc = acceptCyc;
    end
    checkOutput("tput_stalls", 64'(totalWaited), 64'd0);
    waitRsp(8);
    if (rspQ.size() >= 8) begin
      checkOutput("tput_latency", 64'(rspCycQ[0] - firstAcc), 64'd2);
      for (int k = 0; k < 8; k++) checkOutput("tput_rsp", rspQ[k], DW'((k + 1) * 3));
    end

    // Backpressure: three credits, then req_rdy holds low until the first pop.
    repeat (3) @(posedge CLK);
    #1;
    rspQ.delete();
    rspCycQ.delete();
    rspRdy   = 1'b0;
    reqVld   = 1'b1;
    reqWr    = 1'b0;
    reqAddr  = 9'd1;
    accepted = 0;
    rdyLow   = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      if (reqRdy) accepted++;
      else        rdyLow++;
      @(posedge CLK);
      #1;
      reqAddr = AW'(accepted + 1);
    end
    reqVld = 1'b0;
    checkOutput("bp_accepted", 64'(accepted), 64'd3);
    checkOutput("bp_rdy_low_cycles", 64'(rdyLow), 64'd10);
    checkOutput("bp_no_early_rsp", 64'(rspQ.size()), 64'd0);
    rspRdy = 1'b1;
    @(negedge CLK);
    checkOutput("bp_rdy_before_pop", {rspVld, reqRdy}, {1'b1, 1'b0});
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checkOutput("bp_rdy_after_pop", 64'(reqRdy), 64'd1);
    waitRsp(3);
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("bp_rsp_count", 64'(rspQ.size()), 64'd3);
    if (rspQ.size() >= 3)
      for (int k = 0; k < 3; k++) checkOutput("bp_rsp", rspQ[k], DW'((k + 1) * 3));

    // Reset with two responses queued and a third read in flight.
    rspRdy = 1'b0;
    for (int a = 4; a <= 6; a++) applyStimulus(1'b0, AW'(a), '0, 2'b00, waited);
    checkOutput("queued_before_rst", 64'(rspVld), 64'd1);
    doReset();
    rspRdy = 1'b1;
    rspQ.delete();
    rspCycQ.delete();
    sweepCheck();
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("no_stale_rsp", 64'(rspQ.size()), 64'd0);

    // Reset in the middle of the sweep, at A=100.
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    checkOutput("sweep_a100", {cen, sramA}, {1'b0, 9'd100});
    doReset();
    sweepCheck();

    rspQ.delete();
    applyStimulus(1'b0, 9'd2, '0, 2'b00, waited);
    waitRsp(1);
    if (rspQ.size() >= 1) checkOutput("rezeroed_rd", rspQ[0], '0);
    checkOutput("noinit_cen_never_low", 64'(cen0Low), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
